// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, reads a combinational ROM and
// queues {pc, instr} pairs for decode. Handles redirect flushes, halt and fetch faults.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

    logic [63:0]   fpc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [64:0] end_addr;
    logic        addr_ok;
    logic        fetch_ok;
    logic        deq;
    logic        enq;

    assign imem_addr = fpc;

    // 65-bit sum so the bounds check cannot wrap near 2^64
    assign end_addr  = {1'b0, fpc} + 65'd3;
    assign addr_ok   = (fpc[1:0] == 2'b00) && (end_addr < MEM_LIMIT);
    assign fetch_ok  = !redirect_valid && !halt && !fault;

    assign out_valid = (count != '0) && !redirect_valid;
    assign deq       = out_valid && out_ready;
    assign enq       = fetch_ok && addr_ok && ((count < CW'(DEPTH)) || deq);

    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fault  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            fpc    <= redirect_target;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fault  <= 1'b0;
        end else begin
            if (enq) begin
                pc_mem[wr_ptr]    <= fpc;
                instr_mem[wr_ptr] <= imem_instr;
                wr_ptr            <= wr_ptr + PW'(1);
                fpc               <= fpc + 64'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (!enq && deq) begin
                count <= count - CW'(1);
            end
            // fault stays set until a redirect or reset clears it
            if (fetch_ok && !addr_ok) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected {pc, instr}
// deliveries; a negedge monitor pops and compares on every handshake.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t exp_q[$];
    entry_t mon_e;
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    // ROM word n holds 0xC0DE_nnnn; out-of-range reads return a poison value
    assign imem_instr = (imem_addr < 64'd1024) ? {16'hC0DE, imem_addr[17:2]} : 32'hDEAD_BEEF;

    fetch_sequencer #(
        .RESET_PC(64'h0),
        .MEM_SIZE(1024),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .halt(halt),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fault(fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) chk("out_pc_align", 64'(out_pc[1:0]), 64'd0);
            if (dut.count == 2 && !dut.deq) chk("enq_when_full", 64'(dut.enq), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: got pc %0h instr %0h expected none", out_pc, out_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_pc", out_pc, mon_e.pc);
                    chk("out_instr", 64'(out_instr), 64'(mon_e.instr));
                end
            end
        end
    end

    initial begin
        // reset values and fill latency with out_ready=1
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("valid_before_fill", 64'(out_valid), 64'd0);
        push(64'd0, 32'hC0DE_0000);
        push(64'd4, 32'hC0DE_0001);
        push(64'd8, 32'hC0DE_0002);
        push(64'd12, 32'hC0DE_0003);
        tick();
        chk("valid_after_fill", 64'(out_valid), 64'd1);
        repeat (4) tick();
        out_ready = 1'b0;
        chk("drain_stream", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_head", out_pc, 64'd16);
        chk("full_fpc", imem_addr, 64'd24);

        // asynchronous reset with a full queue
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_fault", 64'(fault), 64'd0);
        chk("async_addr", imem_addr, 64'd0);

        // saturation with out_ready=0, then back-to-back drain
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_valid", 64'(out_valid), 64'd1);
            chk("held_pc", out_pc, 64'd0);
            chk("held_instr", 64'(out_instr), 64'h0000_0000_C0DE_0000);
        end
        chk("sat_fpc", imem_addr, 64'd8);
        push(64'd0, 32'hC0DE_0000);
        push(64'd4, 32'hC0DE_0001);
        push(64'd8, 32'hC0DE_0002);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b0;
        chk("drain_b2b", 64'(exp_q.size()), 64'd0);
        chk("two_queued_head", out_pc, 64'd12);

        // redirect to 0x40 with two entries queued
        redirect_valid  = 1'b1;
        redirect_target = 64'h40;
        out_ready       = 1'b1;
        #1;
        chk("redir_cycle_valid", 64'(out_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("bubble_valid", 64'(out_valid), 64'd0);
        chk("redir_fpc", imem_addr, 64'h40);
        push(64'h40, 32'hC0DE_0010);
        push(64'h44, 32'hC0DE_0011);
        tick();
        chk("redir_valid_rise", 64'(out_valid), 64'd1);
        repeat (2) tick();
        out_ready = 1'b0;
        chk("drain_redir", 64'(exp_q.size()), 64'd0);

        // run off the end of the ROM
        redirect_valid  = 1'b1;
        redirect_target = 64'd1012;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        push(64'd1012, 32'hC0DE_00FD);
        push(64'd1016, 32'hC0DE_00FE);
        push(64'd1020, 32'hC0DE_00FF);
        repeat (4) tick();
        chk("end_fault", 64'(fault), 64'd1);
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_fpc", imem_addr, 64'd1024);
        chk("drain_end", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
        chk("sticky_fault", 64'(fault), 64'd1);
        chk("sticky_valid", 64'(out_valid), 64'd0);
        chk("sticky_fpc", imem_addr, 64'd1024);
        redirect_valid  = 1'b1;
        redirect_target = 64'd0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("fault_cleared", 64'(fault), 64'd0);
        chk("clear_valid", 64'(out_valid), 64'd0);
        push(64'd0, 32'hC0DE_0000);
        tick();
        chk("recover_valid", 64'(out_valid), 64'd1);
        tick();
        out_ready = 1'b0;
        chk("drain_recover", 64'(exp_q.size()), 64'd0);

        // misaligned redirect target
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h6;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("misalign_fault_pre", 64'(fault), 64'd0);
        chk("misalign_fpc", imem_addr, 64'h6);
        tick();
        chk("misalign_fault", 64'(fault), 64'd1);
        chk("misalign_valid", 64'(out_valid), 64'd0);
        chk("misalign_hold", imem_addr, 64'h6);

        // halt mid-stream
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 64'h100;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        chk("prehalt_fpc", imem_addr, 64'h108);
        chk("prehalt_valid", 64'(out_valid), 64'd1);
        halt      = 1'b1;
        out_ready = 1'b1;
        push(64'h100, 32'hC0DE_0040);
        push(64'h104, 32'hC0DE_0041);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_fpc", imem_addr, 64'h108);
        end
        chk("halt_drained", 64'(out_valid), 64'd0);
        halt = 1'b0;
        push(64'h108, 32'hC0DE_0042);
        push(64'h10C, 32'hC0DE_0043);
        tick();
        chk("resume_fpc", imem_addr, 64'h10C);
        chk("resume_valid", 64'(out_valid), 64'd1);
        repeat (2) tick();
        out_ready = 1'b0;
        chk("drain_halt", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
